// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader: state encodings,
// default word geometry and the bit-counter width helper.
package serial_word_loader_pkg;

  // Default word MSB index; the word itself is W_DEF+1 bits wide.
  localparam int W_DEF  = 4;
  localparam int WW_DEF = W_DEF + 1;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Bit counter must hold 0..msb; sized with one spare code for headroom.
  function automatic int bit_cnt_width(input int msb);
    return $clog2(msb + 2);
  endfunction

endpackage

// File: rtl/serial_word_loader_if.sv
// Serial input and parallel word output bundle of the serial word loader.
// master = the loader, slave = the environment feeding bits / taking words.
interface serial_word_loader_if
  import serial_word_loader_pkg::*;
#(
  parameter int w  = W_DEF,
  parameter int CW = CW_DEF
);
  logic          sin;
  logic          sin_vld;
  logic [w:0]    out;
  logic          out_vld;
  logic          out_rdy;
  logic          busy;
  logic          ovf;
  logic [CW-1:0] wcnt;

  modport master (
    input  sin, sin_vld, out_rdy,
    output out, out_vld, busy, ovf, wcnt
  );

  modport slave (
    output sin, sin_vld, out_rdy,
    input  out, out_vld, busy, ovf, wcnt
  );
endinterface

// File: rtl/serial_word_loader_sipo_reg.sv
// Serial-in / parallel-out shift register, MSB first, with shift enable
// and synchronous clear.
module sipo_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH == 1) begin : g_single
      // Degenerate one-bit register: each shift simply replaces the bit.
      always_ff @(posedge clk) begin
        if (!rst_b || clr) q <= '0;
        else if (en)       q <= din;
      end
    end else begin : g_multi
      // New bit enters at the LSB so the first bit ends up as the MSB.
      always_ff @(posedge clk) begin
        if (!rst_b || clr) q <= '0;
        else if (en)       q <= {q[WIDTH-2:0], din};
      end
    end
  endgenerate

endmodule

// File: rtl/serial_word_loader.sv
// Serial word loader: finds a start bit on a 1-bit stream, shifts in
// w+1 data bits MSB first and presents the word on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a start bit (sin=1 with sin_vld)
// SHIFT | collecting data bits, busy=1
// HOLD  | word presented on out with out_vld=1 until accepted
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int w  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_b,
  serial_word_loader_if.master bus
);

  localparam int WW = w + 1;
  localparam int BW = bit_cnt_width(w);

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [WW-1:0] out_q;
  logic [WW-1:0] out_d;
  logic          out_vld_q, out_vld_d;
  logic          busy_q;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          load_out;
  logic          sh_clr;
  logic          sh_en;
  logic          xfer;
  logic [w-1:0]  sh_q;

  // The final data bit is taken straight from sin, so the shift register
  // only needs the w bits already received.
  sipo_reg #(.WIDTH(w)) u_sipo (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (sh_clr),
    .en    (sh_en),
    .din   (bus.sin),
    .q     (sh_q)
  );

  assign out_d = {sh_q, bus.sin};
  assign xfer  = out_vld_q && bus.out_rdy;

  // State, bit counter, handshake and status registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      out_vld_q <= out_vld_d;
      busy_q    <= (state_d == SHIFT);
      ovf_q     <= ovf_d;
      wcnt_q    <= wcnt_d;
    end
  end

  // Output word register; keeps its value after a transfer.
  always_ff @(posedge clk) begin
    if (!rst_b)        out_q <= '0;
    else if (load_out) out_q <= out_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    out_vld_d = out_vld_q;
    ovf_d     = ovf_q;
    wcnt_d    = wcnt_q;
    load_out  = 1'b0;
    sh_clr    = 1'b0;
    sh_en     = 1'b0;

    case (state_q)
      IDLE: begin
        out_vld_d = 1'b0;
        if (bus.sin_vld && bus.sin) begin
          state_d = SHIFT;
          bcnt_d  = '0;
          sh_clr  = 1'b1;
        end
      end

      SHIFT: begin
        if (bus.sin_vld) begin
          sh_en = 1'b1;
          if (bcnt_q == BW'(w)) begin
            state_d   = HOLD;
            bcnt_d    = '0;
            load_out  = 1'b1;
            out_vld_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      HOLD: begin
        if (xfer) begin
          wcnt_d    = wcnt_q + 1'b1;
          out_vld_d = 1'b0;
          if (bus.sin_vld && bus.sin) begin
            // Start bit arriving with the acceptance: no idle gap needed.
            state_d = SHIFT;
            bcnt_d  = '0;
            sh_clr  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.sin_vld) begin
          // Nowhere to put the bit while a word is still pending.
          ovf_d = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        bcnt_d    = '0;
        out_vld_d = 1'b0;
      end
    endcase
  end

  assign bus.out     = out_q;
  assign bus.out_vld = out_vld_q;
  assign bus.busy    = busy_q;
  assign bus.ovf     = ovf_q;
  assign bus.wcnt    = wcnt_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader (w=4, CW=8) with a word scoreboard.
module tb_serial_word_loader;

  logic clk;
  logic rst_b;

  serial_word_loader_if #(.w(4), .CW(8)) bus ();

  serial_word_loader #(.w(4), .CW(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          frames   = 0;
  int          o_hits   = 0;
  logic [31:0] seen     = '0;
  logic [4:0]  exp_q[$];

  function automatic logic checker_o(input logic [4:0] v);
    return ((int'(v) + 3) % 4) == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe a transfer mid-cycle, then return 1 time unit after
  // the rising edge so the caller can drive inputs and sample outputs.
  task automatic tick();
    logic [4:0] e;
    @(negedge clk);
    if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 32'(bus.out), 32'h0);
        n_fail += (bus.out === 5'd0) ? 1 : 0;
      end else begin
        e = exp_q.pop_front();
        chk("xfer_word", 32'(bus.out), 32'(e));
        chk("xfer_checker_o", 32'(checker_o(bus.out)), 32'(checker_o(e)));
        if (checker_o(bus.out)) o_hits++;
        seen[bus.out] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [4:0] word, input int gap, input bit chk_busy);
    exp_q.push_back(word);
    frames++;
    bus.sin_vld = 1'b1;
    bus.sin     = 1'b1;
    tick();
    if (chk_busy) chk("busy_after_start", 32'(bus.busy), 32'd1);
    for (int g = 0; g < gap; g++) begin
      bus.sin_vld = 1'b0;
      tick();
      if (chk_busy) chk("busy_stall", 32'(bus.busy), 32'd1);
    end
    for (int i = 4; i >= 0; i--) begin
      bus.sin_vld = 1'b1;
      bus.sin     = word[i];
      tick();
      if (i != 0) begin
        if (chk_busy) chk("busy_bit", 32'(bus.busy), 32'd1);
        for (int g = 0; g < gap; g++) begin
          bus.sin_vld = 1'b0;
          tick();
          if (chk_busy) chk("busy_stall", 32'(bus.busy), 32'd1);
        end
      end
    end
    bus.sin_vld = 1'b0;
    bus.sin     = 1'b0;
    chk("frame_out_vld", 32'(bus.out_vld), 32'd1);
    chk("frame_out", 32'(bus.out), 32'(word));
    chk("frame_busy_low", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [4:0] held;
    rst_b       = 1'b0;
    bus.sin     = 1'b0;
    bus.sin_vld = 1'b0;
    bus.out_rdy = 1'b0;
    tick();
    tick();
    chk("rst_out", 32'(bus.out), 32'h0);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_wcnt", 32'(bus.wcnt), 32'd0);
    rst_b = 1'b1;

    // Single frame with consumer ready.
    bus.out_rdy = 1'b1;
    send_frame(5'b00101, 0, 1'b1);
    tick();
    chk("t1_out_vld_fall", 32'(bus.out_vld), 32'd0);
    chk("t1_out_kept", 32'(bus.out), 32'h05);
    chk("t1_wcnt", 32'(bus.wcnt), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);

    // Stalled frame, then a second frame decoding to checker o=0.
    send_frame(5'b00101, 2, 1'b1);
    tick();
    send_frame(5'b00110, 0, 1'b1);
    tick();
    chk("t2_wcnt", 32'(bus.wcnt), 32'(frames));
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure for 4 cycles, then accept with the next start bit.
    bus.out_rdy = 1'b0;
    send_frame(5'b01100, 0, 1'b0);
    held = bus.out;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_hold_out", 32'(bus.out), 32'h0C);
      chk("t3_hold_vld", 32'(bus.out_vld), 32'd1);
      chk("t3_hold_ovf", 32'(bus.ovf), 32'd0);
    end
    bus.out_rdy = 1'b1;
    send_frame(5'b11111, 0, 1'b1);
    tick();
    chk("t3_wcnt", 32'(bus.wcnt), 32'(frames));

    // Overrun while holding an unaccepted word.
    bus.out_rdy = 1'b0;
    send_frame(5'b01001, 0, 1'b0);
    bus.sin_vld = 1'b1;
    bus.sin     = 1'b0;
    tick();
    bus.sin_vld = 1'b0;
    chk("t4_ovf_set", 32'(bus.ovf), 32'd1);
    chk("t4_out_same", 32'(bus.out), 32'h09);
    chk("t4_still_vld", 32'(bus.out_vld), 32'd1);
    chk("t4_not_busy", 32'(bus.busy), 32'd0);
    bus.out_rdy = 1'b1;
    tick();
    tick();
    chk("t4_ovf_sticky", 32'(bus.ovf), 32'd1);
    chk("t4_vld_low", 32'(bus.out_vld), 32'd0);
    chk("t4_wcnt", 32'(bus.wcnt), 32'(frames));
    if (held !== 5'b01100) chk("t3_held_sample", 32'(held), 32'h0C);

    // Reset after three data bits of a frame.
    bus.sin_vld = 1'b1;
    bus.sin = 1'b1; tick();
    bus.sin = 1'b1; tick();
    bus.sin = 1'b0; tick();
    bus.sin = 1'b1; tick();
    chk("t5_busy_pre", 32'(bus.busy), 32'd1);
    rst_b = 1'b0;
    tick();
    rst_b       = 1'b1;
    bus.sin_vld = 1'b0;
    frames      = 0;
    chk("t5_out", 32'(bus.out), 32'h0);
    chk("t5_out_vld", 32'(bus.out_vld), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_wcnt", 32'(bus.wcnt), 32'd0);
    chk("t5_ovf", 32'(bus.ovf), 32'd0);
    send_frame(5'b10011, 0, 1'b0);
    tick();
    chk("t5_wcnt_after", 32'(bus.wcnt), 32'd1);

    // 256 accepted frames wrap wcnt and cover all word values.
    rst_b = 1'b0;
    tick();
    rst_b  = 1'b1;
    frames = 0;
    o_hits = 0;
    seen   = '0;
    for (int k = 0; k < 256; k++) begin
      send_frame(5'(k), 0, 1'b0);
    end
    tick();
    chk("t6_wcnt_wrap", 32'(bus.wcnt), 32'(frames % 256));
    chk("t6_wcnt_zero", 32'(bus.wcnt), 32'd0);
    chk("t6_all_words", seen, 32'hFFFF_FFFF);
    chk("t6_o_hits", 32'(o_hits), 32'd64);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
